pe_issue_arbiter: RTL

- Shares one PE core between NUM_REQ requesters.
- Round-robin arbitration; issues at most one op per cycle into the PE core's 2-stage pipeline.
- Tracks in-flight requester tags and routes each PE result back to its owner.
- Flags PE opcodes that produce no result, enforces a per-requester outstanding-op limit, and supports enable/drain for quiescing the PE.

---
 rtl/pe_issue_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pe_issue_arbiter.sv
// pe_issue_arbiter: round-robin issue of NUM_REQ requesters into one
// pipelined PE core, with tag tracking and per-owner result routing.
module pe_issue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int PE_LATENCY = 2,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_opcode,
  input  logic [32*NUM_REQ-1:0] req_op1,
  input  logic [32*NUM_REQ-1:0] req_op2,
  input  logic [32*NUM_REQ-1:0] req_op3,
  output logic [31:0]           pe_opcode,
  output logic [31:0]           pe_op1,
  output logic [31:0]           pe_op2,
  output logic [31:0]           pe_op3,
  output logic                  pe_valid_in,
  input  logic [31:0]           pe_result,
  input  logic                  pe_result_valid,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  err_spurious,
  output logic                  idle,
  output logic [3:0]            inflight
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int SW    = IW + 1;
  localparam int DEPTH = PE_LATENCY + 1;
  localparam logic [2:0] MAXC = 3'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      ptr;
  logic [2:0]         cnt [NUM_REQ];
  logic               hs;
  logic               found;
  logic [SW-1:0]      scan;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      gnt_id;
  logic [31:0]        sel_opc;
  logic [31:0]        sel_op1;
  logic [31:0]        sel_op2;
  logic [31:0]        sel_op3;
  logic [DEPTH-1:0]   tag_v;
  logic [IW-1:0]      tag_id [DEPTH];
  logic               out_v;
  logic [IW-1:0]      out_id;
  logic [NUM_REQ-1:0] out_hot;

  // First eligible requester scanning from ptr; grants stop as soon
  // as enable drops, even before the state register follows.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    found     = 1'b0;
    scan      = '0;
    idx       = '0;
    if (state == S_RUN && enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, ptr} + SW'(k);
        if (scan >= SW'(NUM_REQ))
          scan = scan - SW'(NUM_REQ);
        idx = scan[IW-1:0];
        if (!found && req_valid[idx] &&
            cnt[idx] < MAXC) begin
          found          = 1'b1;
          req_ready[idx] = 1'b1;
          gnt_id         = idx;
        end
      end
    end
  end

  assign hs = found;

  always_comb begin
    sel_opc = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    sel_op3 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_opc = req_opcode[32*i +: 32];
        sel_op1 = req_op1[32*i +: 32];
        sel_op2 = req_op2[32*i +: 32];
        sel_op3 = req_op3[32*i +: 32];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NUM_REQ; i++)
      inflight = inflight + 4'(cnt[i]);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (enable) state_nxt = S_RUN;
      S_RUN:
        if (!enable) state_nxt = S_DRAIN;
      S_DRAIN:
        if (enable) state_nxt = S_RUN;
        else if (inflight == 4'd0)
          state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign idle = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        if (gnt_id == IW'(NUM_REQ - 1))
          ptr <= '0;
        else
          ptr <= gnt_id + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_opcode   <= '0;
      pe_op1      <= '0;
      pe_op2      <= '0;
      pe_op3      <= '0;
      pe_valid_in <= 1'b0;
    end else begin
      pe_valid_in <= hs;
      if (hs) begin
        pe_opcode <= sel_opc;
        pe_op1    <= sel_op1;
        pe_op2    <= sel_op2;
        pe_op3    <= sel_op3;
      end
    end
  end

  // Tag slot DEPTH-1 lines up with the cycle the PE result is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < DEPTH; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[DEPTH-2:0], hs};
      tag_id[0] <= gnt_id;
      for (int i = 1; i < DEPTH; i++)
        tag_id[i] <= tag_id[i-1];
    end
  end

  assign out_v   = tag_v[DEPTH-1];
  assign out_id  = tag_id[DEPTH-1];
  assign out_hot = out_v ? (NUM_REQ'(1) << out_id)
                         : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      rsp_valid <= out_hot;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      if (out_v) begin
        if (pe_result_valid)
          rsp_data <= pe_result;
        else
          rsp_err <= 1'b1;
      end else if (pe_result_valid) begin
        err_spurious <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && !out_hot[i])
          cnt[i] <= cnt[i] + 3'd1;
        else if (!req_ready[i] && out_hot[i])
          cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

endmodule
